// File: rtl/wave_pkg.sv
// ---------------------------------------------------------------------------
// wave_pkg
// Shared types and constants for the wave_mixer block:
//   env_state_t  - envelope generator states
//   ENV_MAX      - full-scale envelope level (8-bit)
//   LFSR_TAP*    - feedback taps of the 16-bit noise LFSR
//   DEFAULT_SEED - power-on LFSR value (any nonzero value is legal)
//   lfsr_next()  - one LFSR step
// ---------------------------------------------------------------------------
package wave_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } env_state_t;

    localparam logic [7:0]  ENV_MAX      = 8'd255;
    localparam logic [15:0] DEFAULT_SEED = 16'd773;

    localparam int LFSR_TAP0 = 15;
    localparam int LFSR_TAP1 = 14;
    localparam int LFSR_TAP2 = 12;
    localparam int LFSR_TAP3 = 3;

    // Fibonacci shift-left; with these taps a nonzero state never maps to 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[LFSR_TAP0] ^ s[LFSR_TAP1] ^ s[LFSR_TAP2] ^ s[LFSR_TAP3]};
    endfunction

endpackage

// File: rtl/wave_mixer_if.sv
// ---------------------------------------------------------------------------
// wave_mixer_if
// Sample-rate bus between the oscillator bank / control side (master) and
// the wave_mixer (slave).
//   sample_tick  1-cycle strobe, one output sample per tick
//   gate         note on/off
//   ch_en        per-channel enable            [NCH]
//   ch_gain      per-channel right shift 0..15 [4*NCH], ch i at [4i+3:4i]
//   sig_in       channel samples               [W*NCH], ch i at [W*i+W-1:W*i]
//   noise_en     add LFSR noise as an extra channel
//   mix_out      mixed, saturated, enveloped sample [W]
//   mix_valid    1-cycle pulse when mix_out updates
//   clip         sample in mix_out was saturated
// ---------------------------------------------------------------------------
interface wave_mixer_if #(
    parameter int NCH = 4,
    parameter int W   = 16
);
    logic               sample_tick;
    logic               gate;
    logic [NCH-1:0]     ch_en;
    logic [4*NCH-1:0]   ch_gain;
    logic [W*NCH-1:0]   sig_in;
    logic               noise_en;
    logic [W-1:0]       mix_out;
    logic               mix_valid;
    logic               clip;

    modport master (
        output sample_tick, gate, ch_en, ch_gain, sig_in, noise_en,
        input  mix_out, mix_valid, clip
    );

    modport slave (
        input  sample_tick, gate, ch_en, ch_gain, sig_in, noise_en,
        output mix_out, mix_valid, clip
    );
endinterface

// File: rtl/noise_lfsr16.sv
// ---------------------------------------------------------------------------
// noise_lfsr16
// 16-bit LFSR noise source. Steps once per cycle while adv is high and holds
// otherwise. Loads SEED on reset.
//   clk    in   system clock
//   rst_n  in   asynchronous reset, active low
//   adv    in   advance one step this cycle
//   q      out  current LFSR state
// ---------------------------------------------------------------------------
module noise_lfsr16
    import wave_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adv,
    output logic [15:0] q
);

    logic [15:0] lfsr_d;
    logic [15:0] lfsr_q;

    always_comb begin
        lfsr_d = lfsr_q;
        if (adv) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/wave_mixer.sv
// ---------------------------------------------------------------------------
// wave_mixer
// N-channel waveform mixer with optional LFSR noise channel, saturating
// unsigned sum and a linear attack/release envelope used as a click-free gate.
// A sample_tick at cycle T yields mix_valid at T+3; one tick per cycle is
// accepted.
//   clk    in     system clock
//   rst_n  in     asynchronous reset, active low
//   bus    slave  wave_mixer_if (tick, gate, channel controls, mixed output)
// ---------------------------------------------------------------------------
module wave_mixer
    import wave_pkg::*;
#(
    parameter int          NCH        = 4,
    parameter int          W          = 16,
    parameter int          ENV_STEP   = 1,
    parameter logic [15:0] NOISE_SEED = DEFAULT_SEED
) (
    input  logic         clk,
    input  logic         rst_n,
    wave_mixer_if.slave  bus
);

    // Wide enough for NCH channels plus noise, each up to 2^W-1.
    localparam int         SW    = W + $clog2(NCH + 2);
    localparam logic [8:0] STEP9 = 9'(ENV_STEP);

    // {clip, value}: clamp the wide sum to the W-bit range.
    function automatic logic [W:0] saturate(input logic [SW-1:0] s);
        if (|s[SW-1:W]) begin
            return {1'b1, {W{1'b1}}};
        end
        return {1'b0, s[W-1:0]};
    endfunction

    // In SUSTAIN the sample passes untouched; elsewhere scale by env/256.
    function automatic logic [W-1:0] apply_env(input logic [W-1:0] x,
                                               input logic [7:0]   e,
                                               input logic         sustain);
        logic [W+7:0] p;
        p = {8'b0, x} * {{W{1'b0}}, e};
        return sustain ? x : p[W+7:8];
    endfunction

    // ------------------------------------------------------------------
    // Envelope generator and noise source (update on tick)
    // ------------------------------------------------------------------
    env_state_t  state_d, state_q;
    logic [7:0]  env_d,   env_q;
    logic [8:0]  env_up_sum;
    logic [7:0]  env_up,  env_dn;
    logic [15:0] lfsr_q;

    assign env_up_sum = {1'b0, env_q} + STEP9;
    assign env_up     = env_up_sum[8] ? ENV_MAX : env_up_sum[7:0];
    assign env_dn     = ({1'b0, env_q} <= STEP9) ? 8'd0 : (env_q - STEP9[7:0]);

    // The gate level on the tick picks the ramp direction, so a gate flip
    // mid-ramp continues from the current level instead of jumping.
    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        if (bus.sample_tick) begin
            if (bus.gate) begin
                if (state_q == SUSTAIN) begin
                    env_d = ENV_MAX;
                end else begin
                    env_d   = env_up;
                    state_d = (env_up == ENV_MAX) ? SUSTAIN : ATTACK;
                end
            end else if (state_q != IDLE) begin
                env_d   = env_dn;
                state_d = (env_dn == 8'd0) ? IDLE : RELEASE;
            end else begin
                env_d = 8'd0;
            end
        end
    end

    noise_lfsr16 #(
        .SEED (NOISE_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (bus.sample_tick & bus.noise_en),
        .q     (lfsr_q)
    );

    // ------------------------------------------------------------------
    // Stage A (T+1): attenuated channel terms, envelope snapshot
    // ------------------------------------------------------------------
    logic         vld_p0_d,      vld_p0_q;
    logic [W-1:0] term_p0_d [NCH];
    logic [W-1:0] term_p0_q [NCH];
    logic         noise_en_p0_d, noise_en_p0_q;
    logic [7:0]   env_p0_d,      env_p0_q;
    logic         sus_p0_d,      sus_p0_q;

    always_comb begin
        vld_p0_d      = bus.sample_tick;
        noise_en_p0_d = noise_en_p0_q;
        env_p0_d      = env_p0_q;
        sus_p0_d      = sus_p0_q;
        for (int i = 0; i < NCH; i++) begin
            term_p0_d[i] = term_p0_q[i];
        end
        if (bus.sample_tick) begin
            for (int i = 0; i < NCH; i++) begin
                term_p0_d[i] = bus.ch_en[i] ? (bus.sig_in[W*i +: W] >> bus.ch_gain[4*i +: 4])
                                            : '0;
            end
            noise_en_p0_d = bus.noise_en;
            env_p0_d      = env_d;
            sus_p0_d      = (state_d == SUSTAIN);
        end
    end

    // ------------------------------------------------------------------
    // Stage B (T+2): sum and saturation
    // ------------------------------------------------------------------
    // The LFSR has already stepped on this sample's tick, so lfsr_q during
    // stage A is exactly the post-advance value; a following tick only
    // moves it at the next edge.
    logic [W-1:0]  noise_term;
    logic [SW-1:0] sum;
    logic [W:0]    sat_res;
    logic          vld_p1_d,  vld_p1_q;
    logic [W-1:0]  sat_p1_d,  sat_p1_q;
    logic          clip_p1_d, clip_p1_q;
    logic [7:0]    env_p1_d,  env_p1_q;
    logic          sus_p1_d,  sus_p1_q;

    assign noise_term = noise_en_p0_q ? W'(lfsr_q) : '0;

    always_comb begin
        sum = SW'(noise_term);
        for (int i = 0; i < NCH; i++) begin
            sum = sum + SW'(term_p0_q[i]);
        end
    end

    assign sat_res = saturate(sum);

    always_comb begin
        vld_p1_d  = vld_p0_q;
        sat_p1_d  = sat_p1_q;
        clip_p1_d = clip_p1_q;
        env_p1_d  = env_p1_q;
        sus_p1_d  = sus_p1_q;
        if (vld_p0_q) begin
            sat_p1_d  = sat_res[W-1:0];
            clip_p1_d = sat_res[W];
            env_p1_d  = env_p0_q;
            sus_p1_d  = sus_p0_q;
        end
    end

    // ------------------------------------------------------------------
    // Stage C (T+3): envelope scaling, output registers
    // ------------------------------------------------------------------
    logic         vld_p2_d,  vld_p2_q;
    logic [W-1:0] mix_out_d, mix_out_q;
    logic         clip_d,    clip_q;

    always_comb begin
        vld_p2_d  = vld_p1_q;
        mix_out_d = mix_out_q;
        clip_d    = clip_q;
        if (vld_p1_q) begin
            mix_out_d = apply_env(sat_p1_q, env_p1_q, sus_p1_q);
            clip_d    = clip_p1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            env_q         <= 8'd0;
            vld_p0_q      <= 1'b0;
            noise_en_p0_q <= 1'b0;
            env_p0_q      <= 8'd0;
            sus_p0_q      <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                term_p0_q[i] <= '0;
            end
            vld_p1_q      <= 1'b0;
            sat_p1_q      <= '0;
            clip_p1_q     <= 1'b0;
            env_p1_q      <= 8'd0;
            sus_p1_q      <= 1'b0;
            vld_p2_q      <= 1'b0;
            mix_out_q     <= '0;
            clip_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            env_q         <= env_d;
            vld_p0_q      <= vld_p0_d;
            noise_en_p0_q <= noise_en_p0_d;
            env_p0_q      <= env_p0_d;
            sus_p0_q      <= sus_p0_d;
            for (int i = 0; i < NCH; i++) begin
                term_p0_q[i] <= term_p0_d[i];
            end
            vld_p1_q      <= vld_p1_d;
            sat_p1_q      <= sat_p1_d;
            clip_p1_q     <= clip_p1_d;
            env_p1_q      <= env_p1_d;
            sus_p1_q      <= sus_p1_d;
            vld_p2_q      <= vld_p2_d;
            mix_out_q     <= mix_out_d;
            clip_q        <= clip_d;
        end
    end

    assign bus.mix_out   = mix_out_q;
    assign bus.mix_valid = vld_p2_q;
    assign bus.clip      = clip_q;

endmodule

// File: tb/tb_wave_mixer.sv
// ---------------------------------------------------------------------------
// tb_wave_mixer
// Directed bench for wave_mixer with NCH=4, W=16, ENV_STEP=16.
// ---------------------------------------------------------------------------
module tb_wave_mixer;
    import wave_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    wave_mixer_if #(.NCH(4), .W(16)) bus ();

    wave_mixer #(
        .NCH        (4),
        .W          (16),
        .ENV_STEP   (16),
        .NOISE_SEED (16'd773)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic set_ch(input int ch, input logic [15:0] val, input logic [3:0] gain);
        bus.sig_in[16*ch +: 16] = val;
        bus.ch_gain[4*ch +: 4]  = gain;
    endtask

    // One tick; returns at the third falling edge after the tick edge, where
    // the sample must be on mix_out. early flags a valid seen before that.
    task automatic run_tick(output bit early);
        early = 1'b0;
        @(negedge clk);
        bus.sample_tick = 1'b1;
        @(negedge clk);
        bus.sample_tick = 1'b0;
        if (bus.mix_valid) early = 1'b1;
        @(negedge clk);
        if (bus.mix_valid) early = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.sample_tick = 1'b0;
        bus.gate        = 1'b0;
        bus.ch_en       = '0;
        bus.ch_gain     = '0;
        bus.sig_in      = '0;
        bus.noise_en    = 1'b0;
        rst_n           = 1'b0;
        #23;
        vectors++; if (bus.mix_out !== 16'h0000) begin miscompares++; $display("FAIL reset_mix_out: got %h want 0000", bus.mix_out); end
        vectors++; if (bus.mix_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", bus.mix_valid); end
        vectors++; if (bus.clip !== 1'b0) begin miscompares++; $display("FAIL reset_clip: got %b want 0", bus.clip); end
        vectors++; if (dut.u_lfsr.lfsr_q !== 16'd773) begin miscompares++; $display("FAIL reset_lfsr: got %0d want 773", dut.u_lfsr.lfsr_q); end
        vectors++; if (dut.state_q !== IDLE) begin miscompares++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (bus.mix_valid !== 1'b0) begin miscompares++; $display("FAIL idle_valid: got %b want 0", bus.mix_valid); end
    endtask

    // ch0=1000 + ch1=2000 = 3000; ch2 carries data but is disabled.
    task automatic test_attack();
        bit early;
        int exp_out;
        bus.ch_en = 4'b0011;
        set_ch(0, 16'd1000, 4'd0);
        set_ch(1, 16'd2000, 4'd0);
        set_ch(2, 16'd5000, 4'd1);
        bus.gate = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            run_tick(early);
            exp_out = (k >= 16) ? 3000 : (3000 * 16 * k) / 256;
            vectors++; if (early) begin miscompares++; $display("FAIL attack_latency tick %0d: valid seen early, want exactly 3 cycles", k); end
            vectors++; if (bus.mix_valid !== 1'b1) begin miscompares++; $display("FAIL attack_valid tick %0d: got %b want 1", k, bus.mix_valid); end
            vectors++; if (bus.mix_out !== 16'(exp_out)) begin miscompares++; $display("FAIL attack_out tick %0d: got %0d want %0d", k, bus.mix_out, exp_out); end
        end
        vectors++; if (dut.state_q !== SUSTAIN) begin miscompares++; $display("FAIL attack_state: got %0d want SUSTAIN", dut.state_q); end
        vectors++; if (dut.env_q !== 8'd255) begin miscompares++; $display("FAIL attack_env: got %0d want 255", dut.env_q); end
        @(negedge clk);
        vectors++; if (bus.mix_valid !== 1'b0) begin miscompares++; $display("FAIL attack_pulse: got %b want 0", bus.mix_valid); end
    endtask

    task automatic test_clip();
        bit early;
        bus.ch_en = 4'b0011;
        set_ch(0, 16'hC000, 4'd0);
        set_ch(1, 16'hC000, 4'd0);
        run_tick(early);
        vectors++; if (bus.mix_out !== 16'hFFFF) begin miscompares++; $display("FAIL clip_out: got %h want FFFF", bus.mix_out); end
        vectors++; if (bus.clip !== 1'b1) begin miscompares++; $display("FAIL clip_flag: got %b want 1", bus.clip); end
        bus.ch_en = 4'b0001;
        run_tick(early);
        vectors++; if (bus.mix_out !== 16'hC000) begin miscompares++; $display("FAIL noclip_out: got %h want C000", bus.mix_out); end
        vectors++; if (bus.clip !== 1'b0) begin miscompares++; $display("FAIL noclip_flag: got %b want 0", bus.clip); end
    endtask

    task automatic test_gain();
        bit early;
        bus.ch_en = 4'b0001;
        set_ch(0, 16'h8000, 4'd3);
        run_tick(early);
        vectors++; if (bus.mix_out !== 16'h1000) begin miscompares++; $display("FAIL gain3: got %h want 1000", bus.mix_out); end
        set_ch(0, 16'h8000, 4'd15);
        run_tick(early);
        vectors++; if (bus.mix_out !== 16'h0001) begin miscompares++; $display("FAIL gain15: got %h want 0001", bus.mix_out); end
    endtask

    // LFSR has not stepped yet (noise_en was low): 0x0305 -> 0x060A -> 0x0C15.
    task automatic test_noise();
        bit early;
        bus.ch_en    = 4'b0000;
        bus.noise_en = 1'b1;
        run_tick(early);
        vectors++; if (bus.mix_out !== 16'h060A) begin miscompares++; $display("FAIL noise_first: got %h want 060A", bus.mix_out); end
        run_tick(early);
        vectors++; if (bus.mix_out !== 16'h0C15) begin miscompares++; $display("FAIL noise_second: got %h want 0C15", bus.mix_out); end
        bus.noise_en = 1'b0;
        run_tick(early);
        vectors++; if (dut.u_lfsr.lfsr_q !== 16'h0C15) begin miscompares++; $display("FAIL noise_hold: got %h want 0C15", dut.u_lfsr.lfsr_q); end
    endtask

    task automatic test_reset_mid();
        bit early;
        bus.ch_en = 4'b0011;
        set_ch(0, 16'hC000, 4'd0);
        set_ch(1, 16'hC000, 4'd0);
        run_tick(early);
        vectors++; if (bus.mix_out !== 16'hFFFF) begin miscompares++; $display("FAIL premid_out: got %h want FFFF", bus.mix_out); end
        @(negedge clk);
        bus.sample_tick = 1'b1;
        @(negedge clk);
        bus.sample_tick = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (bus.mix_out !== 16'h0000) begin miscompares++; $display("FAIL mid_rst_out: got %h want 0000", bus.mix_out); end
        vectors++; if (bus.mix_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid: got %b want 0", bus.mix_valid); end
        vectors++; if (bus.clip !== 1'b0) begin miscompares++; $display("FAIL mid_rst_clip: got %b want 0", bus.clip); end
        vectors++; if (dut.u_lfsr.lfsr_q !== 16'd773) begin miscompares++; $display("FAIL mid_rst_lfsr: got %0d want 773", dut.u_lfsr.lfsr_q); end
        vectors++; if (dut.env_q !== 8'd0) begin miscompares++; $display("FAIL mid_rst_env: got %0d want 0", dut.env_q); end
        bus.gate = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++; if (bus.mix_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_dropped cycle %0d: got %b want 0", i, bus.mix_valid); end
        end
        run_tick(early);
        vectors++; if (early || bus.mix_valid !== 1'b1) begin miscompares++; $display("FAIL post_rst_latency: early %b valid %b want 0/1", early, bus.mix_valid); end
        vectors++; if (bus.mix_out !== 16'h0000) begin miscompares++; $display("FAIL post_rst_idle_out: got %h want 0000", bus.mix_out); end
    endtask

    // sat fixed at 1000, so out = (1000*env)>>8.
    task automatic test_release();
        bit early;
        logic [15:0] att_exp [5];
        logic [15:0] rel_exp [5];
        logic [15:0] re_exp  [5];
        logic        re_gate [5];
        att_exp = '{16'd62, 16'd125, 16'd187, 16'd250, 16'd312};
        rel_exp = '{16'd250, 16'd187, 16'd125, 16'd62, 16'd0};
        re_exp  = '{16'd250, 16'd187, 16'd125, 16'd187, 16'd250};
        re_gate = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        bus.ch_en = 4'b0001;
        set_ch(0, 16'd1000, 4'd0);
        bus.gate = 1'b1;
        for (int k = 0; k < 5; k++) begin
            run_tick(early);
            vectors++; if (bus.mix_out !== att_exp[k]) begin miscompares++; $display("FAIL rel_attack %0d: got %0d want %0d", k, bus.mix_out, att_exp[k]); end
        end
        bus.gate = 1'b0;
        for (int k = 0; k < 5; k++) begin
            run_tick(early);
            vectors++; if (bus.mix_out !== rel_exp[k]) begin miscompares++; $display("FAIL rel_release %0d: got %0d want %0d", k, bus.mix_out, rel_exp[k]); end
        end
        vectors++; if (dut.state_q !== IDLE) begin miscompares++; $display("FAIL rel_idle: got %0d want IDLE", dut.state_q); end
        bus.gate = 1'b1;
        for (int k = 0; k < 5; k++) run_tick(early);
        bus.gate = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (dut.env_q !== 8'd80) begin miscompares++; $display("FAIL gate_no_tick_env: got %0d want 80", dut.env_q); end
        vectors++; if (dut.state_q !== ATTACK) begin miscompares++; $display("FAIL gate_no_tick_state: got %0d want ATTACK", dut.state_q); end
        for (int k = 0; k < 5; k++) begin
            bus.gate = re_gate[k];
            run_tick(early);
            vectors++; if (bus.mix_out !== re_exp[k]) begin miscompares++; $display("FAIL reattack %0d: got %0d want %0d", k, bus.mix_out, re_exp[k]); end
        end
        vectors++; if (dut.env_q !== 8'd64) begin miscompares++; $display("FAIL reattack_env: got %0d want 64", dut.env_q); end
    endtask

    task automatic test_back_to_back();
        bit early;
        logic [15:0] vals [4];
        vals = '{16'd100, 16'd200, 16'd300, 16'd400};
        bus.gate = 1'b1;
        for (int k = 0; k < 12; k++) run_tick(early);
        vectors++; if (dut.state_q !== SUSTAIN) begin miscompares++; $display("FAIL b2b_sustain: got %0d want SUSTAIN", dut.state_q); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i >= 3 && i <= 6) begin
                vectors++; if (bus.mix_valid !== 1'b1 || bus.mix_out !== vals[i-3]) begin miscompares++; $display("FAIL b2b_out %0d: got valid %b out %0d want 1 %0d", i, bus.mix_valid, bus.mix_out, vals[i-3]); end
            end else begin
                vectors++; if (bus.mix_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_idle %0d: got valid %b want 0", i, bus.mix_valid); end
            end
            if (i < 4) begin
                bus.sample_tick = 1'b1;
                set_ch(0, vals[i], 4'd0);
            end else begin
                bus.sample_tick = 1'b0;
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_attack();
        test_clip();
        test_gain();
        test_noise();
        test_reset_mid();
        test_release();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
